// File: rtl/iq_alu_issue_queue_pkg.sv
// Shared types for the dispatch -> ALU issue queue path.
// - p_i_pkg_t          : dispatch packet. Holds two instruction slots with two operands each.
// - cdb_dispatch_pkg_t : one common-data-bus wakeup port.
// - rob_id_t           : physical register / ROB id.
// - iq_entry_t         : one issue-queue entry.
// The payload field is sized for the widest queue payload. Narrower
// instances use the low PAYLOAD_W bits and leave the rest at zero.
package iq_alu_issue_queue_pkg;

  localparam int ROB_ID_W     = 6;
  localparam int IQ_DATA_W    = 32;
  localparam int IQ_PAYLOAD_W = 32;

  typedef logic [ROB_ID_W-1:0] rob_id_t;

  typedef struct packed {
    logic [3:0][IQ_DATA_W-1:0] data;
    rob_id_t [3:0]             preg;
    logic [3:0]                data_valid;
    logic [1:0]                inst_choose;
  } p_i_pkg_t;

  typedef struct packed {
    logic                 w_reg;
    rob_id_t              w_preg;
    logic [IQ_DATA_W-1:0] w_data;
  } cdb_dispatch_pkg_t;

  typedef struct packed {
    logic                      valid;
    logic [1:0]                src_valid;
    rob_id_t [1:0]             src_preg;
    logic [1:0][IQ_DATA_W-1:0] src_data;
    logic [IQ_PAYLOAD_W-1:0]   payload;
  } iq_entry_t;

  // Number of instruction slots present in a dispatch packet (0..2).
  function automatic logic [1:0] slots_in(input logic [1:0] choose);
    return {1'b0, choose[0]} + {1'b0, choose[1]};
  endfunction

endpackage

// File: rtl/iq_alu_issue_queue_wakeup.sv
// Compares one operand against both CDB ports.
// Inputs:
// - cdb   : the two wakeup ports.
// - preg  : tag of the operand.
// - valid : the operand already holds data.
// - data  : the operand's current value.
// Outputs:
// - hit      : a pending operand matched a CDB port.
// - data_out : the captured value on a hit, otherwise data.
// When both ports match, port 1 wins.
module iq_wakeup
  import iq_alu_issue_queue_pkg::*;
#(
  parameter int PREG_W = ROB_ID_W,
  parameter int DATA_W = IQ_DATA_W
) (
  input  cdb_dispatch_pkg_t [1:0] cdb,
  input  logic [PREG_W-1:0]       preg,
  input  logic                    valid,
  input  logic [DATA_W-1:0]       data,
  output logic                    hit,
  output logic [DATA_W-1:0]       data_out
);

  logic hit0;
  logic hit1;

  assign hit0     = cdb[0].w_reg && (cdb[0].w_preg == preg);
  assign hit1     = cdb[1].w_reg && (cdb[1].w_preg == preg);
  assign hit      = !valid && (hit0 || hit1);
  assign data_out = !hit ? data : (hit1 ? cdb[1].w_data : cdb[0].w_data);

endmodule

// File: rtl/iq_alu_issue_queue.sv
// Issue queue for one ALU. Entries are kept age-ordered and compacted;
// index 0 holds the oldest entry.
// Ports:
// - clk, rst : clock and synchronous active-high reset.
// - flush_i  : synchronous pipeline flush.
// - p_i_*    : dispatch handshake. Carries up to two instructions per packet.
// - cdb_i    : two wakeup ports.
// - i_fu_*   : valid/ready issue handshake to the ALU.
// - count_o  : number of occupied entries.
module iq_alu_issue_queue
  import iq_alu_issue_queue_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int PREG_W    = ROB_ID_W,
  parameter int DATA_W    = IQ_DATA_W,
  parameter int PAYLOAD_W = IQ_PAYLOAD_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         p_i_valid_i,
  output logic                         p_i_ready_o,
  input  p_i_pkg_t                     p_i_pkg_i,
  input  logic [1:0][PAYLOAD_W-1:0]    p_i_payload_i,
  input  cdb_dispatch_pkg_t [1:0]      cdb_i,
  output logic                         i_fu_valid_o,
  input  logic                         i_fu_ready_i,
  output logic [1:0][DATA_W-1:0]       i_fu_data_o,
  output logic [PAYLOAD_W-1:0]         i_fu_payload_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);

  iq_entry_t         entries_reg  [DEPTH];
  iq_entry_t         woken        [DEPTH];
  iq_entry_t         shifted      [DEPTH];
  iq_entry_t         entries_next [DEPTH];
  iq_entry_t         incoming     [2];
  logic [CNT_W-1:0]  count_reg, count_next, surv, pos1;
  logic              lock_reg;
  logic [IDX_W-1:0]  lock_idx_reg;
  logic              cand_found;
  logic [IDX_W-1:0]  cand_idx;
  logic              issue, enq;

  logic              hit_st   [DEPTH][2];
  logic [DATA_W-1:0] wdata_st [DEPTH][2];
  logic              hit_in   [4];
  logic [DATA_W-1:0] wdata_in [4];

  // Wakeup comparators for stored operands.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    for (genvar gk = 0; gk < 2; gk++) begin : g_src
      iq_wakeup #(.PREG_W(PREG_W), .DATA_W(DATA_W)) u_wakeup (
        .cdb      (cdb_i),
        .preg     (entries_reg[gi].src_preg[gk]),
        .valid    (entries_reg[gi].src_valid[gk]),
        .data     (entries_reg[gi].src_data[gk]),
        .hit      (hit_st[gi][gk]),
        .data_out (wdata_st[gi][gk])
      );
    end
  end

  // Wakeup comparators for the four incoming operands. These catch a
  // broadcast in the same cycle the instruction arrives.
  for (genvar gi = 0; gi < 4; gi++) begin : g_in
    iq_wakeup #(.PREG_W(PREG_W), .DATA_W(DATA_W)) u_wakeup (
      .cdb      (cdb_i),
      .preg     (p_i_pkg_i.preg[gi]),
      .valid    (p_i_pkg_i.data_valid[gi]),
      .data     (p_i_pkg_i.data[gi]),
      .hit      (hit_in[gi]),
      .data_out (wdata_in[gi])
    );
  end

  // Select. Once an entry is presented and not yet accepted, it stays
  // locked as the candidate. This keeps the output stable even if an
  // older entry wakes up meanwhile. Without an issue nothing shifts,
  // so the locked index stays correct.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    if (lock_reg) begin
      cand_found = 1'b1;
      cand_idx   = lock_idx_reg;
    end else begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (entries_reg[i].valid && (&entries_reg[i].src_valid)) begin
          cand_found = 1'b1;
          cand_idx   = IDX_W'(i);
        end
      end
    end
  end

  assign issue          = cand_found && i_fu_ready_i;
  assign i_fu_valid_o   = cand_found;
  assign i_fu_data_o[0] = cand_found ? entries_reg[cand_idx].src_data[0] : '0;
  assign i_fu_data_o[1] = cand_found ? entries_reg[cand_idx].src_data[1] : '0;
  assign i_fu_payload_o = cand_found ? entries_reg[cand_idx].payload[PAYLOAD_W-1:0] : '0;
  assign p_i_ready_o    = (count_reg <= CNT_W'(DEPTH - 2));
  assign enq            = p_i_valid_i && p_i_ready_o;
  assign count_o        = count_reg;

  always_comb begin
    // Apply this cycle's wakeups to the stored entries.
    for (int i = 0; i < DEPTH; i++) begin
      woken[i] = entries_reg[i];
      for (int k = 0; k < 2; k++) begin
        if (hit_st[i][k]) begin
          woken[i].src_valid[k] = 1'b1;
          woken[i].src_data[k]  = wdata_st[i][k];
        end
      end
    end

    // Close the gap left by the issued entry.
    for (int i = 0; i < DEPTH; i++) begin
      if (issue && (IDX_W'(i) >= cand_idx)) begin
        if (i < DEPTH - 1) shifted[i] = woken[i+1];
        else               shifted[i] = '0;
      end else begin
        shifted[i] = woken[i];
      end
    end

    // Build the entries for both incoming slots.
    for (int j = 0; j < 2; j++) begin
      incoming[j]       = '0;
      incoming[j].valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
        incoming[j].src_preg[k]  = p_i_pkg_i.preg[2*j+k];
        incoming[j].src_valid[k] = p_i_pkg_i.data_valid[2*j+k] | hit_in[2*j+k];
        incoming[j].src_data[k]  = wdata_in[2*j+k];
      end
      incoming[j].payload[PAYLOAD_W-1:0] = p_i_payload_i[j];
    end

    // Append present slots behind the surviving entries. The ready
    // rule guarantees there are at least two free slots.
    surv = count_reg - CNT_W'(issue);
    pos1 = surv + CNT_W'(p_i_pkg_i.inst_choose[0]);
    for (int i = 0; i < DEPTH; i++) begin
      entries_next[i] = shifted[i];
      if (enq && p_i_pkg_i.inst_choose[0] && (CNT_W'(i) == surv)) entries_next[i] = incoming[0];
      if (enq && p_i_pkg_i.inst_choose[1] && (CNT_W'(i) == pos1)) entries_next[i] = incoming[1];
    end
    count_next = surv + (enq ? CNT_W'(slots_in(p_i_pkg_i.inst_choose)) : '0);
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      for (int i = 0; i < DEPTH; i++) entries_reg[i] <= '0;
      count_reg    <= '0;
      lock_reg     <= 1'b0;
      lock_idx_reg <= '0;
    end else begin
      entries_reg  <= entries_next;
      count_reg    <= count_next;
      lock_reg     <= cand_found && !i_fu_ready_i;
      lock_idx_reg <= cand_idx;
    end
  end

endmodule
